// File: rtl/serial_byte_receiver.sv
// 8N1 asynchronous serial receiver, LSB first, oversampled at CLKS_PER_BIT clocks per bit.
// Define SERIAL_BYTE_RECEIVER_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_byte_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       load,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             load_q, load_d;
  logic             ferr_q, ferr_d;
  logic             rxd_meta_q, rxs_q;
  logic             rxs;

  assign rxs = rxs_q;

  // Two-flop synchroniser, preset to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit re-check filters out glitches shorter than half a bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rxs != ^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              load_d = 1'b1;
            end
`else
            data_d = shift_q;
            load_d = 1'b1;
`endif
          end else begin
            // A low stop bit wins over any parity result.
            ferr_d  = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= 8'h00;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
    end
  end

  // The partial byte is never observable before all eight bits are written, so it needs no reset.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = data_q;
  assign load      = load_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: directed frames, a vector table and random frames
// checked against a frame-level outcome model.
module tb_serial_byte_receiver;

  localparam int CPB = 4;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd   = 1'b1;
  logic [7:0] data_out;
  logic       load, busy, frame_err, parity_err;

  serial_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .data_out   (data_out),
    .load       (load),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observer: logs strobes and counts protocol violations
  logic [7:0] load_log[$];
  int cyc = 0, ferr_cnt = 0, perr_cnt = 0, viol = 0, last_load_cyc = 0;

  initial begin
    logic       p_load, p_ferr, p_perr, p_busy, p_rst;
    logic [7:0] p_dout;
    p_load = 0; p_ferr = 0; p_perr = 0; p_busy = 0; p_rst = 0; p_dout = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset && p_rst) begin
        if (load) begin
          load_log.push_back(data_out);
          last_load_cyc = cyc;
          if (!p_busy) viol++;
        end
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        if ((int'(load) + int'(frame_err) + int'(parity_err)) > 1) viol++;
        if ((load && p_load) || (frame_err && p_ferr) || (parity_err && p_perr)) viol++;
        if (!load && (data_out !== p_dout)) viol++;
      end
      p_load = load; p_ferr = frame_err; p_perr = parity_err;
      p_busy = busy; p_dout = data_out; p_rst = reset;
    end
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ ~par_ok);
    drive_bit(stop);
  endtask

  task automatic frame_check(input string tag, input int n0, input int f0, input int p0,
                             input int exp_load, input int exp_ferr, input int exp_perr,
                             input logic [7:0] exp_dout);
    check($sformatf("%s load count", tag), load_log.size() - n0, exp_load);
    check($sformatf("%s frame_err count", tag), ferr_cnt - f0, exp_ferr);
    check($sformatf("%s parity_err count", tag), perr_cnt - p0, exp_perr);
    check($sformatf("%s data_out", tag), data_out, exp_dout);
    if (exp_load > 0 && load_log.size() > 0)
      check($sformatf("%s loaded byte", tag), load_log[load_log.size()-1], exp_dout);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_load;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0, f0, p0, c0, lat_exp;
    logic [7:0] held;

    vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 2, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    vecs[5] = '{8'h5A, 1'b0, 3, 0, 1, 8'hFF};
    vecs[6] = '{8'h01, 1'b1, 1, 1, 0, 8'h01};

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("reset data_out", data_out, 8'h00);
    check("reset load", load, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset parity_err", parity_err, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle_bits(2);

    // 0xA5: one load, busy through the frame, latency from start edge
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt; c0 = cyc;
    drive_bit(1'b0);
    check("A5 busy in start bit", busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(8'hA5 >> i);
    if (PAR) drive_bit(^8'hA5);
    drive_bit(1'b1);
    idle_bits(2);
    frame_check("A5", n0, f0, p0, 1, 0, 0, 8'hA5);
    lat_exp = (PAR ? 10 : 9) * CPB + CPB / 2 + 3;
    check("A5 load latency", last_load_cyc - c0, lat_exp);
    check("A5 busy after frame", busy, 0);

    // One-clock glitch on the line
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    rxd = 1'b0;
    @(negedge clock);
    rxd = 1'b1;
    repeat (6) @(negedge clock);
    check("glitch busy dropped", busy, 0);
    idle_bits(1);
    frame_check("glitch", n0, f0, p0, 0, 0, 0, 8'hA5);

    // Bad stop bit, line held low 20 bits, then recovery
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) drive_bit(1'b0);
    frame_check("break 3C", n0, f0, p0, 0, 1, 0, 8'hA5);
    check("break busy held", busy, 1);
    idle_bits(2);
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h81, 1'b1, 1'b1);
    idle_bits(2);
    frame_check("after break 81", n0, f0, p0, 1, 0, 0, 8'h81);

    // Back-to-back frames with no idle gap
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle_bits(2);
    frame_check("b2b", n0, f0, p0, 2, 0, 0, 8'hFF);
    if (load_log.size() >= n0 + 2) check("b2b first byte", load_log[n0], 8'h00);

    // Reset during bit 4 of 0x55
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h55 >> i);
    rxd = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset data_out", data_out, 8'h00);
    check("midreset busy", busy, 0);
    check("midreset load", load, 0);
    check("midreset frame_err", frame_err, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle_bits(2);
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h55, 1'b1, 1'b1);
    idle_bits(2);
    frame_check("after reset 55", n0, f0, p0, 1, 0, 0, 8'h55);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(vecs[v].data, vecs[v].stop, 1'b1);
      idle_bits(vecs[v].gap);
      frame_check($sformatf("vec%0d", v), n0, f0, p0, vecs[v].exp_load, vecs[v].exp_ferr, 0,
                  vecs[v].exp_dout);
    end

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit must be 1
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h07 >> i);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle_bits(2);
    frame_check("parity bad 07", n0, f0, p0, 0, 0, 1, 8'h01);
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h07 >> i);
    drive_bit(1'b1);
    drive_bit(1'b1);
    idle_bits(2);
    frame_check("parity good 07", n0, f0, p0, 1, 0, 0, 8'h07);
    n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h33, 1'b0, 1'b0);
    idle_bits(2);
    frame_check("parity+stop bad", n0, f0, p0, 0, 1, 0, 8'h07);
`endif

    // Random frames against the frame-outcome model
    held = data_out;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      logic       stop, par_ok;
      int         e_load, e_ferr, e_perr;
      b      = 8'($urandom);
      stop   = ($urandom_range(0, 9) != 0);
      par_ok = PAR ? ($urandom_range(0, 6) != 0) : 1'b1;
      e_load = 0; e_ferr = 0; e_perr = 0;
      if (!stop) e_ferr = 1;
      else if (!par_ok) e_perr = 1;
      else begin
        e_load = 1;
        held   = b;
      end
      n0 = load_log.size(); f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(b, stop, par_ok);
      idle_bits($urandom_range(1, 3));
      frame_check($sformatf("rand%0d", k), n0, f0, p0, e_load, e_ferr, e_perr, held);
    end

    check("strobe/data_out protocol violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
